cpu_control_mc: RTL
===================

Name: cpu_control_mc

Overview:
Multicycle control FSM for the accumulator CPU, successor to the fixed 4-state sequencer. It adds ready/req handshakes to instruction and data memory with unbounded wait states and a programmable bus timeout. It also adds a parametrised opcode width with illegal-opcode trapping, single-step mode, halt/resume, and a retired-instruction counter. It drives the PC, IR, accumulator and memory enables; the datapath is unchanged apart from the pc_skip input.

Parameters:
OPC_W, 3, opcode width (>=3); codes >= 8 are illegal.
CNT_W, 16, retired-instruction counter width.
TIMEOUT_CYC, 255, max wait cycles per memory request before error; 0 disables timeout.
TMO_W, 8, wait-counter width; must hold TIMEOUT_CYC.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
opcode  in  OPC_W  opcode from IR; stable from the cycle after ir_load.
is_zero  in  1  accumulator == 0.
imem_ready  in  1  instruction memory completes the current request.
dmem_ready  in  1  data memory completes the current read/write.
step_mode  in  1  pause after every retired instruction.
resume  in  1  single-cycle pulse that leaves HALTED.
imem_req  out  1  instruction fetch request.
ir_load  out  1  latch instruction word into IR.
dmem_req  out  1  data memory request.
dmem_we  out  1  data write (valid with dmem_req).
acc_load  out  1  load accumulator.
acc_sel  out  1  1 = accumulator from memory (LDA), 0 = from ALU.
pc_inc  out  1  PC += 1 (PC += 2 when pc_skip also set).
pc_skip  out  1  skip the next instruction.
pc_load  out  1  PC <= operand address (JMP).
halted  out  1  FSM is in HALTED.
err_illegal  out  1  sticky: illegal opcode trapped.
err_timeout  out  1  sticky: memory timeout.
retired_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Opcode map: 0 HALT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP; any value >= 8 is illegal.
- States: IDLE, FETCH, DECODE, MEMRD, MEMWR, WB, HALTED. rst forces IDLE asynchronously.
- Reset: all outputs 0, wait counter 0, error flags 0, retired_cnt 0. Reset mid-request drops req the same instant.
- IDLE: -> FETCH after 1 cycle.
- FETCH: imem_req=1. ir_load=imem_ready (combinational). On ready -> DECODE; otherwise stay.
- DECODE (1 cycle): the next state depends on the opcode.
  - HALT: pc_inc=1, then -> HALTED.
  - Illegal: set err_illegal, no pc update, then -> HALTED.
  - SKZ/JMP: -> WB.
  - ADD/AND/XOR/LDA: -> MEMRD.
  - STO: -> MEMWR.
- MEMRD: dmem_req=1, dmem_we=0; on dmem_ready -> WB.
- MEMWR: dmem_req=1, dmem_we=1; on dmem_ready -> WB.
- WB (1 cycle):
  - acc_load=1 for ADD/AND/XOR/LDA; acc_sel=1 only for LDA.
  - JMP: pc_load=1, pc_inc=0.
  - All other opcodes: pc_inc=1, and pc_skip=SKZ & is_zero.
  - retired_cnt += 1, wrapping modulo 2^CNT_W.
  - Next state: HALTED if step_mode=1 (sampled this cycle), else FETCH.
- HALTED: halted=1, all other strobes 0.
  - resume=1 with both error flags 0 -> FETCH next cycle.
  - resume is ignored while any error flag is set; only rst clears errors.
  - resume is ignored in every other state.
- Wait counter: clears on entry to FETCH/MEMRD/MEMWR and increments each cycle the ready input is low.
  - If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC with ready still low: set err_timeout, drop req next cycle, -> HALTED.
  - If ready is high in the same cycle as the limit is reached, ready wins and there is no error.
- Zero-wait latency: ALU/LDA/STO take 4 cycles (FETCH, DECODE, MEM, WB); SKZ/JMP take 3 cycles.
- Never assert pc_load and pc_inc together. Never assert imem_req and dmem_req together.
- is_zero is sampled only in WB.
- HALT is not counted in retired_cnt.

Test Plan:
1. Reset, then ADD with imem_ready/dmem_ready tied to 1 -> state sequence IDLE, FETCH, DECODE, MEMRD, WB. In WB: acc_load=1, acc_sel=0, pc_inc=1. retired_cnt=1 after 5 cycles.
2. LDA with dmem_ready low for 3 cycles -> dmem_req held 4 cycles, then WB with acc_sel=1. With TIMEOUT_CYC=2, the same stimulus -> err_timeout=1 and halted=1; a following resume is ignored.
3. SKZ with is_zero=1 -> WB asserts pc_inc=1 and pc_skip=1. With is_zero=0 -> pc_skip=0. JMP -> pc_load=1, pc_inc=0, 3 cycles.
4. OPC_W=4, opcode=9 -> err_illegal=1, halted=1, no pc strobe, retired_cnt unchanged. rst -> flags clear, FSM in IDLE.
5. step_mode=1, run STO -> dmem_we=1 in MEMWR, then HALTED. A resume pulse -> FETCH next cycle. HALT opcode -> pc_inc in DECODE, then halted=1.
6. CNT_W=2, retire 5 instructions -> retired_cnt reads 1, 2, 3, 0, 1. Assert rst while in MEMRD -> dmem_req=0 immediately and all outputs 0.

Source files
------------

// File: rtl/cpu_control_mc.sv
// Multicycle control FSM for the accumulator CPU.
// Sequences fetch/decode/memory/write-back with ready/req handshakes, a
// programmable bus timeout, illegal-opcode trapping, single-step and halt/resume,
// and keeps a count of retired instructions.
module cpu_control_mc #(
  parameter int OPC_W       = 3,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 255,
  parameter int TMO_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             is_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             step_mode,
  input  logic             resume,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             acc_load,
  output logic             acc_sel,
  output logic             pc_inc,
  output logic             pc_skip,
  output logic             pc_load,
  output logic             halted,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_MEMWR  = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  localparam logic [2:0] OP_HALT = 3'd0;
  localparam logic [2:0] OP_SKZ  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_LDA  = 3'd5;
  localparam logic [2:0] OP_STO  = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [2:0]       op;
  logic             op_illegal;
  logic             waiting;
  logic             ready_cur;
  logic             timeout_hit;
  logic [TMO_W-1:0] wait_cnt;

  assign op = opcode[2:0];

  // Any set bit above the low three opcode bits means a code >= 8, which is illegal.
  generate
    if (OPC_W > 3) begin : g_wide_opc
      assign op_illegal = |opcode[OPC_W-1:3];
    end else begin : g_narrow_opc
      assign op_illegal = 1'b0;
    end
  endgenerate

  // The wait counter and timeout only apply to the three handshake states.
  assign waiting   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign ready_cur = (state == S_FETCH) ? imem_ready : dmem_ready;

  // Ready arriving in the limit cycle wins; only a still-low ready at the limit trips.
  assign timeout_hit = (TIMEOUT_CYC != 0) && waiting && !ready_cur &&
                       (wait_cnt == TMO_W'(TIMEOUT_CYC));

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (timeout_hit)     state_nxt = S_HALTED;
        else if (imem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (op_illegal) begin
          state_nxt = S_HALTED;
        end else begin
          case (op)
            OP_HALT:        state_nxt = S_HALTED;
            OP_SKZ, OP_JMP: state_nxt = S_WB;
            OP_STO:         state_nxt = S_MEMWR;
            default:        state_nxt = S_MEMRD;
          endcase
        end
      end
      S_MEMRD, S_MEMWR: begin
        if (timeout_hit)     state_nxt = S_HALTED;
        else if (dmem_ready) state_nxt = S_WB;
      end
      S_WB:     state_nxt = step_mode ? S_HALTED : S_FETCH;
      S_HALTED: begin
        if (resume && !err_illegal && !err_timeout) state_nxt = S_FETCH;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Strobes decode from state so reset drops every request the instant rst rises.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    acc_load = 1'b0;
    acc_sel  = 1'b0;
    pc_inc   = 1'b0;
    pc_skip  = 1'b0;
    pc_load  = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      S_DECODE: pc_inc = !op_illegal && (op == OP_HALT);
      S_MEMRD:  dmem_req = 1'b1;
      S_MEMWR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
      end
      S_WB: begin
        acc_load = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        acc_sel  = (op == OP_LDA);
        if (op == OP_JMP) begin
          pc_load = 1'b1;
        end else begin
          pc_inc  = 1'b1;
          pc_skip = (op == OP_SKZ) && is_zero;
        end
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Wait counter restarts on every state change and counts low-ready cycles while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                wait_cnt <= '0;
    else if (state_nxt != state)            wait_cnt <= '0;
    else if (waiting && !ready_cur)         wait_cnt <= wait_cnt + TMO_W'(1);
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if ((state == S_DECODE) && op_illegal) err_illegal <= 1'b1;
      if (timeout_hit)                       err_timeout <= 1'b1;
    end
  end

  // Every write-back retires one instruction; the count wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                retired_cnt <= '0;
    else if (state == S_WB) retired_cnt <= retired_cnt + CNT_W'(1);
  end

endmodule
